mem_bus_responder: RTL and testbench
====================================

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, meaning the number of 16-bit RAM words (a power of two, at most 4096).
REQ-002 SHALL have parameter HEX_COUNT, default 6, meaning the number of seven-segment registers (at most 8).
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 SHALL have port addr, input, 16 bits: the processor bus address.
REQ-006 SHALL have port dout, input, 16 bits: the processor write data.
REQ-007 SHALL have port W, input, 1 bit: the processor write strobe.
REQ-008 SHALL have port DIN, output, 16 bits: the read data returned to the processor.
REQ-009 SHALL have port SW, input, 9 bits: the asynchronous switch inputs.
REQ-010 SHALL have port LEDR, output, 9 bits: the LED register.
REQ-011 SHALL have port HEX, output, 7*HEX_COUNT bits: the seven-segment registers, with register i at bits [7i+6:7i].

Function
REQ-012 SHALL decode the region from addr[15:12] as: 0 = RAM, 1 = LED, 2 = HEX, 3 = SW, 4 = TIMER, any other value = unmapped.
REQ-013 SHALL, for RAM, use word index addr[log2(RAM_WORDS)-1:0]; upper offset bits are ignored, so the RAM aliases within its region.
REQ-014 SHALL give every read exactly one cycle of latency: DIN during cycle t+1 reflects the addr sampled at edge t, for all regions.
REQ-015 SHALL register the decoded region and sub-select alongside the synchronous RAM read, so that the DIN mux stays aligned with RAM data.
REQ-016 SHALL perform a write at edge t when W=1, into the register or RAM word selected by addr.
REQ-017 SHALL return old data on a read-during-write to the same location, in every region.
REQ-018 SHALL, for LED: write LEDR <= dout[8:0]; a read returns {7'b0, LEDR}.
REQ-019 SHALL, for HEX: select the register with addr[2:0]; a write stores dout[6:0]; an index >= HEX_COUNT ignores writes and reads 0; a read returns {9'b0, reg}.
REQ-020 SHALL, for SW: pass SW through a two-flop synchronizer; a read returns {7'b0, sw_sync}; writes are ignored.
REQ-021 SHALL, for TIMER: offset 0 = COUNT and offset 1 = STATUS (addr[0]); other offset bits are ignored.
REQ-022 SHALL, on a write to COUNT with value N: set count <= N, done <= 0, running <= (N != 0).
REQ-023 SHALL, each cycle that running=1 and no COUNT write occurs, decrement count by 1; on the 1->0 transition set done <= 1 and running <= 0.
REQ-024 SHALL, on a write to STATUS, clear done; if an expiry occurs in the same cycle, the set wins (done=1).
REQ-025 SHALL let a COUNT write during a countdown reload the count with no expiry generated for the aborted count.
REQ-026 SHALL make a COUNT read return the current count and a STATUS read return {14'b0, running, done}.
REQ-027 SHALL make unmapped reads return 16'h0000 and ignore unmapped writes.

Reset
REQ-028 SHALL, on an edge with Reset=1, clear LEDR, all HEX registers, count, running, done and the synchronizer flops to 0, and force the registered region to unmapped so that DIN=0 in the next cycle.
REQ-029 SHALL let Reset override a simultaneous write; a write with W=1 during reset has no effect, including on RAM.
REQ-030 SHALL leave RAM contents unchanged by reset (the RAM is not initialised).
REQ-031 SHALL, when reset is asserted mid-countdown, stop the timer with count=0 and done=0.

Structure
REQ-032 SHALL place the region codes, the TIMER offsets and the data width (16) in a shared package or include file used by the processor and the testbench.
REQ-033 SHALL implement the timer as one sub-module, bus_timer (ports Clock, Reset, load, clear, wdata, count, running, done); the RAM SHALL be an inferred synchronous single-port array inside mem_bus_responder.

Verification
REQ-034 SHALL verify: write 16'h1234 to 16'h0005, then read 16'h0005 -> DIN=16'h1234 one cycle after addr; read 16'h0105 (alias for RAM_WORDS=256) -> 16'h1234.
REQ-035 SHALL verify: write 16'hFFFF to 16'h1000 -> LEDR=9'h1FF; write 16'h007F to 16'h2007 -> no HEX change and a read of 16'h2007 returns 0.
REQ-036 SHALL verify: SW=9'h0A5 -> a read of 16'h3000 returns 16'h00A5 when issued 3 or more cycles after SW changes.
REQ-037 SHALL verify: write 3 to 16'h4000 -> STATUS = 16'h0002 for 3 cycles, then 16'h0001; write to 16'h4001 -> STATUS = 0.
REQ-038 SHALL verify: expiry edge coincides with a STATUS write -> done=1; a COUNT reload of 5 at count=2 -> 5 further cycles before done.
REQ-039 SHALL verify: Reset asserted mid-countdown with W=1 to 16'h1000 -> LEDR=0, count=0, done=0, DIN=0 next cycle, and RAM word 5 still 16'h1234.

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// Shared bus constants: data width, region codes and timer register offsets.
package mem_bus_responder_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [3:0] {
    RGN_RAM   = 4'h0,
    RGN_LED   = 4'h1,
    RGN_HEX   = 4'h2,
    RGN_SW    = 4'h3,
    RGN_TIMER = 4'h4,
    RGN_NONE  = 4'hF
  } region_t;

  localparam logic TMR_COUNT  = 1'b0;
  localparam logic TMR_STATUS = 1'b1;

  function automatic region_t decode_region(input logic [3:0] nib);
    case (nib)
      4'h0:    return RGN_RAM;
      4'h1:    return RGN_LED;
      4'h2:    return RGN_HEX;
      4'h3:    return RGN_SW;
      4'h4:    return RGN_TIMER;
      default: return RGN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_responder_timer.sv
// Down-counting timer: load starts a countdown, done latches on expiry.
module bus_timer
  import mem_bus_responder_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] count,
  output logic              running,
  output logic              done
);

  logic expire;

  // Expiry is the running 1->0 step; a load in the same cycle aborts it.
  always_comb begin
    expire = running && (count == DATA_W'(1)) && !load;
  end

  // Count/flag register; expiry set has priority over a STATUS clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (load) begin
      count   <= wdata;
      running <= (wdata != '0);
      done    <= 1'b0;
    end else begin
      if (running) count <= count - DATA_W'(1);
      if (expire) begin
        running <= 1'b0;
        done    <= 1'b1;
      end else if (clear) begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-mapped responder: RAM, LED, HEX, switch and timer regions, 1-cycle reads.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 256,
  parameter int unsigned HEX_COUNT = 6
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [15:0]            addr,
  input  logic [DATA_W-1:0]      dout,
  input  logic                   W,
  output logic [DATA_W-1:0]      DIN,
  input  logic [8:0]             SW,
  output logic [8:0]             LEDR,
  output logic [7*HEX_COUNT-1:0] HEX
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  region_t           region;
  region_t           region_q;
  logic              wr_en;
  logic [AW-1:0]     ram_idx;
  logic [2:0]        hex_idx;
  logic              hex_ok;
  logic [DATA_W-1:0] mem [RAM_WORDS];
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] periph_d;
  logic [DATA_W-1:0] periph_q;
  logic [6:0]        hex_reg [HEX_COUNT];
  logic [8:0]        sw_meta;
  logic [8:0]        sw_sync;
  logic [DATA_W-1:0] t_count;
  logic              t_running;
  logic              t_done;
  logic              unused_addr;

  assign region      = decode_region(addr[15:12]);
  assign wr_en       = W && !Reset;
  assign ram_idx     = addr[AW-1:0];
  assign hex_idx     = addr[2:0];
  assign hex_ok      = (32'(hex_idx) < HEX_COUNT);
  assign unused_addr = ^addr[11:0];

  bus_timer u_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .load    (wr_en && region == RGN_TIMER && addr[0] == TMR_COUNT),
    .clear   (wr_en && region == RGN_TIMER && addr[0] == TMR_STATUS),
    .wdata   (dout),
    .count   (t_count),
    .running (t_running),
    .done    (t_done)
  );

  // Synchronous single-port RAM, read-old-data on a same-address write.
  always_ff @(posedge Clock) begin
    if (wr_en && region == RGN_RAM) mem[ram_idx] <= dout;
    ram_q <= mem[ram_idx];
  end

  // Peripheral read value from pre-edge state, so reads during writes see old data.
  always_comb begin
    periph_d = '0;
    case (region)
      RGN_LED:   periph_d = {7'b0, LEDR};
      RGN_HEX:   if (hex_ok) periph_d = {9'b0, hex_reg[hex_idx]};
      RGN_SW:    periph_d = {7'b0, sw_sync};
      RGN_TIMER: periph_d = (addr[0] == TMR_STATUS) ? {14'b0, t_running, t_done} : t_count;
      default:   periph_d = '0;
    endcase
  end

  // Peripheral registers, switch synchronizer and the registered read path.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      region_q <= RGN_NONE;
      periph_q <= '0;
      LEDR     <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
      for (int unsigned i = 0; i < HEX_COUNT; i++) hex_reg[i] <= '0;
    end else begin
      region_q <= region;
      periph_q <= periph_d;
      sw_meta  <= SW;
      sw_sync  <= sw_meta;
      if (wr_en && region == RGN_LED) LEDR <= dout[8:0];
      if (wr_en && region == RGN_HEX && hex_ok) hex_reg[hex_idx] <= dout[6:0];
    end
  end

  // Read mux: RAM data comes from the array register, everything else from periph_q.
  always_comb begin
    DIN = (region_q == RGN_RAM) ? ram_q : periph_q;
  end

  for (genvar g = 0; g < HEX_COUNT; g++) begin : g_hex
    assign HEX[7*g +: 7] = hex_reg[g];
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench: vector table plus hand sequences, DIN checked via a scoreboard queue.
module tb_mem_bus_responder;
  import mem_bus_responder_pkg::*;

  localparam int unsigned HC = 6;

  logic          Clock;
  logic          Reset;
  logic [15:0]   addr;
  logic [15:0]   dout;
  logic          W;
  logic [15:0]   DIN;
  logic [8:0]    SW;
  logic [8:0]    LEDR;
  logic [7*HC-1:0] HEX;

  mem_bus_responder #(.RAM_WORDS(256), .HEX_COUNT(HC)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .addr  (addr),
    .dout  (dout),
    .W     (W),
    .DIN   (DIN),
    .SW    (SW),
    .LEDR  (LEDR),
    .HEX   (HEX)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        chk;
    logic [15:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [15:0] d;
    logic        chk;
    logic [15:0] exp;
    string       name;
  } vec_t;

  sb_t  sbq[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic [7*HC-1:0] hex_exp;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one bus cycle at the falling edge, compare DIN one cycle later.
  task automatic tick(input logic [15:0] a, input logic w, input logic [15:0] d,
                      input logic chk, input logic [15:0] exp, input string nm);
    sb_t e;
    addr = a;
    W    = w;
    dout = d;
    e.chk = chk; e.exp = exp; e.name = nm;
    sbq.push_back(e);
    @(posedge Clock);
    @(negedge Clock);
    e = sbq.pop_front();
    if (e.chk) check(e.name, 64'(DIN), 64'(e.exp));
  endtask

  initial begin
    Reset = 1'b1; W = 1'b0; addr = '0; dout = '0; SW = '0;
    @(negedge Clock);

    // Reset state
    tick(16'h0000, 1'b0, 16'h0, 1'b1, 16'h0000, "reset_din0");
    tick(16'h1000, 1'b0, 16'h0, 1'b1, 16'h0000, "reset_din1");
    Reset = 1'b0;
    check("reset_ledr", 64'(LEDR), 64'h0);
    check("reset_hex", 64'(HEX), 64'h0);

    tick(16'h1000, 1'b1, 16'hFFFF, 1'b0, 16'h0, "led_wr_ffff");
    check("led_all_ones", 64'(LEDR), 64'h1FF);

    vecs.push_back(vec_t'{16'h0005, 1'b1, 16'h1234, 1'b0, 16'h0000, "ram_wr"});
    vecs.push_back(vec_t'{16'h0005, 1'b0, 16'h0000, 1'b1, 16'h1234, "ram_rd"});
    vecs.push_back(vec_t'{16'h0105, 1'b0, 16'h0000, 1'b1, 16'h1234, "ram_alias"});
    vecs.push_back(vec_t'{16'h0FFF, 1'b1, 16'hBEEF, 1'b0, 16'h0000, "ram_wr_top"});
    vecs.push_back(vec_t'{16'h00FF, 1'b0, 16'h0000, 1'b1, 16'hBEEF, "ram_rd_top"});
    vecs.push_back(vec_t'{16'h00FF, 1'b1, 16'h5555, 1'b1, 16'hBEEF, "ram_rdw_old"});
    vecs.push_back(vec_t'{16'h00FF, 1'b0, 16'h0000, 1'b1, 16'h5555, "ram_rd_new"});
    vecs.push_back(vec_t'{16'h1000, 1'b0, 16'h0000, 1'b1, 16'h01FF, "led_rd"});
    vecs.push_back(vec_t'{16'h1000, 1'b1, 16'h0012, 1'b1, 16'h01FF, "led_rdw_old"});
    vecs.push_back(vec_t'{16'h1000, 1'b0, 16'h0000, 1'b1, 16'h0012, "led_rd_new"});
    vecs.push_back(vec_t'{16'h2007, 1'b1, 16'h007F, 1'b1, 16'h0000, "hex7_wr"});
    vecs.push_back(vec_t'{16'h2007, 1'b0, 16'h0000, 1'b1, 16'h0000, "hex7_rd"});
    vecs.push_back(vec_t'{16'h2006, 1'b1, 16'h0033, 1'b0, 16'h0000, "hex6_wr"});
    vecs.push_back(vec_t'{16'h2006, 1'b0, 16'h0000, 1'b1, 16'h0000, "hex6_rd"});
    vecs.push_back(vec_t'{16'h2002, 1'b1, 16'h0041, 1'b1, 16'h0000, "hex2_wr"});
    vecs.push_back(vec_t'{16'h2002, 1'b0, 16'h0000, 1'b1, 16'h0041, "hex2_rd"});
    vecs.push_back(vec_t'{16'h2005, 1'b1, 16'h00FF, 1'b0, 16'h0000, "hex5_wr"});
    vecs.push_back(vec_t'{16'h2005, 1'b0, 16'h0000, 1'b1, 16'h007F, "hex5_rd"});
    vecs.push_back(vec_t'{16'h2002, 1'b1, 16'h0011, 1'b1, 16'h0041, "hex2_rdw_old"});
    vecs.push_back(vec_t'{16'h2002, 1'b0, 16'h0000, 1'b1, 16'h0011, "hex2_rd_new"});
    vecs.push_back(vec_t'{16'h5005, 1'b1, 16'h9999, 1'b1, 16'h0000, "unm_wr"});
    vecs.push_back(vec_t'{16'h5005, 1'b0, 16'h0000, 1'b1, 16'h0000, "unm_rd"});
    vecs.push_back(vec_t'{16'hF123, 1'b0, 16'h0000, 1'b1, 16'h0000, "unm_rd_hi"});
    vecs.push_back(vec_t'{16'h0005, 1'b0, 16'h0000, 1'b1, 16'h1234, "ram_after_unm"});

    foreach (vecs[i])
      tick(vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].chk, vecs[i].exp, vecs[i].name);

    hex_exp = '0;
    hex_exp[2*7 +: 7] = 7'h11;
    hex_exp[5*7 +: 7] = 7'h7F;
    check("hex_bus", 64'(HEX), 64'(hex_exp));
    check("led_after_tbl", 64'(LEDR), 64'h012);

    // Switch synchronizer: valid three edges after the change
    SW = 9'h0A5;
    tick(16'h0000, 1'b0, 16'h0, 1'b0, 16'h0, "sw_wait1");
    tick(16'h0000, 1'b0, 16'h0, 1'b0, 16'h0, "sw_wait2");
    tick(16'h3000, 1'b0, 16'h0, 1'b1, 16'h00A5, "sw_rd");
    tick(16'h3000, 1'b1, 16'hFFFF, 1'b1, 16'h00A5, "sw_wr_ignored");
    tick(16'h3000, 1'b0, 16'h0, 1'b1, 16'h00A5, "sw_rd_after_wr");

    // Timer countdown of 3
    tick(16'h4000, 1'b1, 16'h0003, 1'b0, 16'h0, "tmr_load3");
    for (int i = 0; i < 3; i++)
      tick(16'h4001, 1'b0, 16'h0, 1'b1, 16'h0002, "tmr_running");
    tick(16'h4001, 1'b0, 16'h0, 1'b1, 16'h0001, "tmr_done");
    tick(16'h4000, 1'b0, 16'h0, 1'b1, 16'h0000, "tmr_count0");
    tick(16'h4001, 1'b1, 16'h0, 1'b1, 16'h0001, "tmr_clr_old");
    tick(16'h4001, 1'b0, 16'h0, 1'b1, 16'h0000, "tmr_cleared");

    // Expiry coinciding with a STATUS clear: set wins
    tick(16'h4000, 1'b1, 16'h0002, 1'b0, 16'h0, "tmr_load2");
    tick(16'h4000, 1'b0, 16'h0, 1'b1, 16'h0002, "tmr_cnt2");
    tick(16'h4001, 1'b1, 16'h0, 1'b1, 16'h0002, "tmr_clr_at_exp");
    tick(16'h4001, 1'b0, 16'h0, 1'b1, 16'h0001, "tmr_set_wins");

    // Reload of 5 at count=2: five more cycles, no expiry for the aborted count
    tick(16'h4000, 1'b1, 16'h0004, 1'b0, 16'h0, "tmr_load4");
    tick(16'h4000, 1'b0, 16'h0, 1'b1, 16'h0004, "tmr_cnt4");
    tick(16'h4000, 1'b0, 16'h0, 1'b1, 16'h0003, "tmr_cnt3");
    tick(16'h4000, 1'b1, 16'h0005, 1'b1, 16'h0002, "tmr_reload");
    tick(16'h4000, 1'b0, 16'h0, 1'b1, 16'h0005, "tmr_cnt5");
    for (int i = 0; i < 4; i++)
      tick(16'h4001, 1'b0, 16'h0, 1'b1, 16'h0002, "tmr_reload_run");
    tick(16'h4001, 1'b0, 16'h0, 1'b1, 16'h0001, "tmr_reload_done");

    // Reset mid-countdown with concurrent writes
    tick(16'h4000, 1'b1, 16'h000A, 1'b0, 16'h0, "tmr_load10");
    tick(16'h4000, 1'b0, 16'h0, 1'b1, 16'h000A, "tmr_cnt10");
    tick(16'h4000, 1'b0, 16'h0, 1'b1, 16'h0009, "tmr_cnt9");
    Reset = 1'b1;
    tick(16'h1000, 1'b1, 16'hFFFF, 1'b1, 16'h0000, "rst_led_din");
    tick(16'h0005, 1'b1, 16'hDEAD, 1'b1, 16'h0000, "rst_ram_din");
    Reset = 1'b0;
    check("rst_ledr", 64'(LEDR), 64'h0);
    check("rst_hex", 64'(HEX), 64'h0);
    tick(16'h4000, 1'b0, 16'h0, 1'b1, 16'h0000, "rst_count");
    tick(16'h4001, 1'b0, 16'h0, 1'b1, 16'h0000, "rst_status");
    tick(16'h0005, 1'b0, 16'h0, 1'b1, 16'h1234, "rst_ram_kept");
    tick(16'h4000, 1'b0, 16'h0, 1'b1, 16'h0000, "rst_count_held");
    W = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
